// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the memory line-port arbiter
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - saturating up-counter, sticks at all-ones
module arb_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one slow-memory line port between I-cache and D-cache
// Fixed priority with a starvation override; memory request held until mem_ready.
module mem_arbiter #(
  parameter int ADDR_W   = mem_arb_pkg::ADDR_W,
  parameter int LINE_W   = mem_arb_pkg::LINE_W,
  parameter bit PRIO_D   = 1'b1,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  gnt_cnt_i,
  output logic [CNT_W-1:0]  gnt_cnt_d
);
  import mem_arb_pkg::*;

  localparam int              SW         = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(MAX_WAIT);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic i_pend, d_pend, pick_d, done;

  // The low-priority side is forced through once it has lost MAX_WAIT times in a row.
  always_comb begin
    i_pend = i_read | i_write;
    d_pend = d_read | d_write;
    if (i_pend && d_pend) pick_d = (starve_q == STARVE_MAX) ? !PRIO_D : PRIO_D;
    else                  pick_d = d_pend;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    starve_d    = starve_q;
    unique case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          state_d     = BUSY;
          owner_d     = pick_d ? OWN_D : OWN_I;
          // Write wins when a port raises read and write together.
          mem_write_d = pick_d ? d_write : i_write;
          mem_read_d  = pick_d ? (d_read & ~d_write) : (i_read & ~i_write);
          mem_addr_d  = pick_d ? d_addr : i_addr;
          mem_wdata_d = pick_d ? d_wdata : i_wdata;
          if (pick_d != PRIO_D)
            starve_d = '0;
          else if (i_pend && d_pend && (starve_q != STARVE_MAX))
            starve_d = starve_q + SW'(1);
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d     = RELEASE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      starve_q    <= starve_d;
    end
  end

  assign done      = (state_q == BUSY) && mem_ready;
  assign i_ready   = done && (owner_q == OWN_I);
  assign d_ready   = done && (owner_q == OWN_D);
  assign i_rdata   = (owner_q == OWN_I) ? mem_rdata : '0;
  assign d_rdata   = (owner_q == OWN_D) ? mem_rdata : '0;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  arb_sat_counter #(.W(CNT_W)) u_cnt_i (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (i_ready),
    .count (gnt_cnt_i)
  );

  arb_sat_counter #(.W(CNT_W)) u_cnt_d (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (d_ready),
    .count (gnt_cnt_d)
  );

endmodule
